load_align_unit: RTL and testbench

//  Parametrised memory-stage load path: accepts a load (addr, size, signedness), issues one or two

---
 rtl/load_align_if.sv | 32 +++
 rtl/load_align_unit.sv | 129 ++++++++++++
 tb/tb_load_align_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/load_align_if.sv
// Load-unit handshake bundle: request side, aligned bus read side and result side.
// The slave modport is the load unit itself; master is the core/bus environment.
interface load_align_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_msize;
  logic              req_unsigned;
  logic              bus_req_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_fault;

  modport master (
    output req_valid, req_addr, req_msize, req_unsigned,
    output bus_resp_valid, bus_rdata, resp_ready,
    input  req_ready, bus_req_valid, bus_addr, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_addr, req_msize, req_unsigned,
    input  bus_resp_valid, bus_rdata, resp_ready,
    output req_ready, bus_req_valid, bus_addr, resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// Memory-stage load path: one or two aligned bus reads, beat merge, byte extraction
// and zero/sign extension to DATA_W. Line-crossing loads split or fault per MISALIGN_EN.
module load_align_unit #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int MISALIGN_EN = 1
) (
  input logic         clk,
  input logic         reset,
  load_align_if.slave port
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        msize_reg;
  logic              unsigned_reg;
  logic              cross_reg;
  logic              fault_reg;
  logic [DATA_W-1:0] beat0_reg;
  logic [DATA_W-1:0] data_reg;

  // Request classification, evaluated on the incoming request in IDLE.
  logic [OFF_W-1:0] req_off;
  logic [4:0]       req_bytes;
  logic             req_cross;
  logic             req_fault;

  assign req_off   = port.req_addr[OFF_W-1:0];
  assign req_bytes = 5'd1 << port.req_msize;
  assign req_cross = (5'(req_off) + req_bytes) > 5'(BYTES);
  assign req_fault = (req_bytes > 5'(BYTES)) || (req_cross && (MISALIGN_EN == 0));

  // Result is formed from the beat arriving this cycle so it can be registered on entry to DONE.
  logic [2*DATA_W-1:0] window;
  logic [2*DATA_W-1:0] shifted;
  logic [6:0]          nbits;
  logic                sign_bit;
  logic [DATA_W-1:0]   extended;

  assign window  = (state_reg == RD1) ? {port.bus_rdata, beat0_reg}
                                      : {{DATA_W{1'b0}}, port.bus_rdata};
  assign shifted = window >> {addr_reg[OFF_W-1:0], 3'b000};
  assign nbits   = 7'd8 << msize_reg;

  always_comb begin
    sign_bit = 1'b0;
    case (msize_reg)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[63];
    endcase
    if (unsigned_reg)
      sign_bit = 1'b0;
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    assign extended[gi] = (nbits > 7'(gi)) ? shifted[gi] : sign_bit;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (port.req_valid)      state_next = req_fault ? DONE : RD0;
      RD0:  if (port.bus_resp_valid) state_next = cross_reg ? RD1 : DONE;
      RD1:  if (port.bus_resp_valid) state_next = DONE;
      DONE: if (port.resp_ready)     state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Request latch and beat/result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg     <= '0;
      msize_reg    <= '0;
      unsigned_reg <= 1'b0;
      cross_reg    <= 1'b0;
      fault_reg    <= 1'b0;
      beat0_reg    <= '0;
      data_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (port.req_valid) begin
          addr_reg     <= port.req_addr;
          msize_reg    <= port.req_msize;
          unsigned_reg <= port.req_unsigned;
          cross_reg    <= req_cross;
          fault_reg    <= req_fault;
          data_reg     <= '0;
        end
        RD0: if (port.bus_resp_valid) begin
          beat0_reg <= port.bus_rdata;
          if (!cross_reg)
            data_reg <= extended;
        end
        RD1: if (port.bus_resp_valid)
          data_reg <= extended;
        default: ;
      endcase
    end
  end

  // State-decoded outputs; second beat address wraps naturally at ADDR_W.
  logic [ADDR_W-1:0] base_addr;
  assign base_addr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    port.req_ready     = (state_reg == IDLE);
    port.bus_req_valid = (state_reg == RD0) || (state_reg == RD1);
    port.bus_addr      = (state_reg == RD1) ? base_addr + ADDR_W'(BYTES) : base_addr;
    port.resp_valid    = (state_reg == DONE);
    port.resp_data     = data_reg;
    port.resp_fault    = fault_reg;
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 64-bit split-capable, 64-bit no-split and 32-bit instances.
module tb_load_align_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          sel;
  logic        req_valid, req_unsigned, bus_resp_valid, resp_ready;
  logic [63:0] req_addr, rdata;
  logic [1:0]  req_msize;
  int          n_cmp = 0;
  int          n_err = 0;

  load_align_if #(.DATA_W(64), .ADDR_W(64)) m_if ();
  load_align_if #(.DATA_W(64), .ADDR_W(64)) nm_if ();
  load_align_if #(.DATA_W(32), .ADDR_W(32)) w_if ();

  // Shared stimulus; only the selected instance sees req_valid.
  assign m_if.req_valid      = req_valid && (sel == 0);
  assign m_if.req_addr       = req_addr;
  assign m_if.req_msize      = req_msize;
  assign m_if.req_unsigned   = req_unsigned;
  assign m_if.bus_resp_valid = bus_resp_valid;
  assign m_if.bus_rdata      = rdata;
  assign m_if.resp_ready     = resp_ready;

  assign nm_if.req_valid      = req_valid && (sel == 1);
  assign nm_if.req_addr       = req_addr;
  assign nm_if.req_msize      = req_msize;
  assign nm_if.req_unsigned   = req_unsigned;
  assign nm_if.bus_resp_valid = bus_resp_valid;
  assign nm_if.bus_rdata      = rdata;
  assign nm_if.resp_ready     = resp_ready;

  assign w_if.req_valid      = req_valid && (sel == 2);
  assign w_if.req_addr       = req_addr[31:0];
  assign w_if.req_msize      = req_msize;
  assign w_if.req_unsigned   = req_unsigned;
  assign w_if.bus_resp_valid = bus_resp_valid;
  assign w_if.bus_rdata      = rdata[31:0];
  assign w_if.resp_ready     = resp_ready;

  load_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1)) u_m  (.clk(clk), .reset(reset), .port(m_if));
  load_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(0)) u_nm (.clk(clk), .reset(reset), .port(nm_if));
  load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1)) u_w  (.clk(clk), .reset(reset), .port(w_if));

  logic        o_req_ready, o_bus_req_valid, o_resp_valid, o_resp_fault;
  logic [63:0] o_bus_addr, o_resp_data;

  always_comb begin
    case (sel)
      0: begin
        o_req_ready = m_if.req_ready;   o_bus_req_valid = m_if.bus_req_valid;
        o_bus_addr  = m_if.bus_addr;    o_resp_valid    = m_if.resp_valid;
        o_resp_data = m_if.resp_data;   o_resp_fault    = m_if.resp_fault;
      end
      1: begin
        o_req_ready = nm_if.req_ready;  o_bus_req_valid = nm_if.bus_req_valid;
        o_bus_addr  = nm_if.bus_addr;   o_resp_valid    = nm_if.resp_valid;
        o_resp_data = nm_if.resp_data;  o_resp_fault    = nm_if.resp_fault;
      end
      default: begin
        o_req_ready = w_if.req_ready;          o_bus_req_valid = w_if.bus_req_valid;
        o_bus_addr  = {32'h0, w_if.bus_addr};  o_resp_valid    = w_if.resp_valid;
        o_resp_data = {32'h0, w_if.resp_data}; o_resp_fault    = w_if.resp_fault;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input int s, input logic [63:0] addr, input logic [1:0] msz,
                         input logic uns, input logic [63:0] b0, input logic [63:0] b1, input bit split,
                         input bit fault, input logic [63:0] a0, input logic [63:0] a1,
                         input int waits, input int hold, input logic [63:0] expd);
    sel = s; req_addr = addr; req_msize = msz; req_unsigned = uns; req_valid = 1'b1;
    #1;
    chk({tag, "/req_ready"}, 64'(o_req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    if (fault) begin
      chk({tag, "/no_bus"}, 64'(o_bus_req_valid), 64'd0);
    end else begin
      for (int b = 0; b <= (split ? 1 : 0); b++) begin
        for (int k = 0; k < waits; k++) begin
          chk({tag, "/bus_held"}, 64'(o_bus_req_valid), 64'd1);
          chk({tag, "/early_resp"}, 64'(o_resp_valid), 64'd0);
          tick();
        end
        chk({tag, "/bus_valid"}, 64'(o_bus_req_valid), 64'd1);
        chk({tag, "/bus_addr"}, o_bus_addr, (b != 0) ? a1 : a0);
        rdata = (b != 0) ? b1 : b0;
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
      end
    end
    chk({tag, "/resp_valid"}, 64'(o_resp_valid), 64'd1);
    chk({tag, "/resp_data"}, o_resp_data, expd);
    chk({tag, "/resp_fault"}, 64'(o_resp_fault), 64'(fault));
    $display("txn %s: addr=%h msize=%0d uns=%0b data=%h fault=%0b", tag, addr, msz, uns, o_resp_data, o_resp_fault);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "/hold_valid"}, 64'(o_resp_valid), 64'd1);
      chk({tag, "/hold_data"}, o_resp_data, expd);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "/idle_ready"}, 64'(o_req_ready), 64'd1);
    chk({tag, "/idle_resp"}, 64'(o_resp_valid), 64'd0);
  endtask

  localparam logic [63:0] BEAT = 64'h8877665544332211;

  initial begin
    sel = 0; req_valid = 0; req_unsigned = 0; bus_resp_valid = 0; resp_ready = 0;
    req_addr = '0; rdata = '0; req_msize = '0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst/req_ready", 64'(o_req_ready), 64'd1);
      chk("rst/bus_req_valid", 64'(o_bus_req_valid), 64'd0);
      chk("rst/resp_valid", 64'(o_resp_valid), 64'd0);
      chk("rst/resp_data", o_resp_data, 64'd0);
      chk("rst/resp_fault", 64'(o_resp_fault), 64'd0);
    end
    reset = 1'b0;
    tick();

    do_load("lb_off3",   0, 64'h1003, 2'd0, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 0, 64'h0000000000000044);
    do_load("lb_off7",   0, 64'h1007, 2'd0, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 2, 64'hFFFFFFFFFFFFFF88);
    do_load("lbu_off7",  0, 64'h1007, 2'd0, 1'b1, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 0, 64'h0000000000000088);
    do_load("lh_off6",   0, 64'h1006, 2'd1, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 0, 64'hFFFFFFFFFFFF8877);
    do_load("lwu_wait",  0, 64'h1004, 2'd2, 1'b1, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 2, 0, 64'h0000000088776655);
    do_load("ld_align",  0, 64'h2000, 2'd3, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h2000, 64'h0, 0, 0, BEAT);
    do_load("lw_split",  0, 64'h1006, 2'd2, 1'b0, 64'hDDCC000000000000, 64'h0000000000002211, 1'b1, 1'b0,
            64'h1000, 64'h1008, 1, 0, 64'h000000002211DDCC);
    do_load("lh_wrap64", 0, 64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b0, 64'hAB00000000000000, 64'h00000000000000CD, 1'b1, 1'b0,
            64'hFFFFFFFFFFFFFFF8, 64'h0, 0, 0, 64'hFFFFFFFFFFFFCDAB);
    do_load("nm_lw_mis", 1, 64'h1006, 2'd2, 1'b0, BEAT, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 0, 0, 64'h0);
    do_load("nm_lw_al",  1, 64'h1004, 2'd2, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 0, 64'hFFFFFFFF88776655);
    do_load("w_ld",      2, 64'h100, 2'd3, 1'b0, BEAT, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 0, 0, 64'h0);
    do_load("w_lw_wrap", 2, 64'hFFFFFFFE, 2'd2, 1'b0, 64'hBBAA0000, 64'h00001234, 1'b1, 1'b0,
            64'hFFFFFFFC, 64'h0, 0, 0, 64'h000000001234BBAA);
    do_load("w_lb",      2, 64'h101, 2'd0, 1'b0, 64'h00008000, 64'h0, 1'b0, 1'b0, 64'h100, 64'h0, 0, 0, 64'h00000000FFFFFF80);
    do_load("w_lw_full", 2, 64'h104, 2'd2, 1'b1, 64'hCAFEF00D, 64'h0, 1'b0, 1'b0, 64'h104, 64'h0, 0, 0, 64'h00000000CAFEF00D);

    // Reset while waiting on the second beat of a split load.
    sel = 0; req_addr = 64'h1006; req_msize = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; rdata = 64'hDDCC000000000000; bus_resp_valid = 1'b1;
    tick();
    bus_resp_valid = 1'b0;
    chk("rstmid/rd1_addr", o_bus_addr, 64'h1008);
    #2 reset = 1'b1;
    #1;
    chk("rstmid/req_ready", 64'(o_req_ready), 64'd1);
    chk("rstmid/bus_req_valid", 64'(o_bus_req_valid), 64'd0);
    chk("rstmid/resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rstmid/resp_data", o_resp_data, 64'd0);
    chk("rstmid/resp_fault", 64'(o_resp_fault), 64'd0);
    #2 reset = 1'b0;
    tick();
    rdata = 64'h0000000000002211; bus_resp_valid = 1'b1;
    tick();
    bus_resp_valid = 1'b0;
    chk("late_resp/resp_valid", 64'(o_resp_valid), 64'd0);
    chk("late_resp/bus_req_valid", 64'(o_bus_req_valid), 64'd0);
    chk("late_resp/req_ready", 64'(o_req_ready), 64'd1);
    $display("txn reset_mid_rd1: late bus_resp_valid after reset, resp_valid=%0b", o_resp_valid);
    do_load("after_rst", 0, 64'h1003, 2'd0, 1'b0, BEAT, 64'h0, 1'b0, 1'b0, 64'h1000, 64'h0, 0, 0, 64'h0000000000000044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
